// File: rtl/ysyx_22050133_div_unit_if.sv
// Operand-accept and result-return handshakes of the iterative divider.
// The master drives operands and consumes results; the divider is the slave.
interface ysyx_22050133_div_unit_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            div_valid;
    logic            div_ready;
    logic            divw;
    logic            div_signed;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;

    modport master (
        output flush, div_valid, divw, div_signed, dividend, divisor, out_ready,
        input  div_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  flush, div_valid, divw, div_signed, dividend, divisor, out_ready,
        output div_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/ysyx_22050133_div_unit.sv
// Radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU and their word forms.
// Divide-by-zero and signed overflow finish at accept; others take N CALC cycles.
module ysyx_22050133_div_unit #(
    parameter int XLEN = 64,
    parameter int WLEN = XLEN / 2
) (
    input logic                     clk,
    input logic                     rst_n,
    ysyx_22050133_div_unit_if.slave bus
);
    localparam int              CW    = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          r_state, w_next;
    logic            r_divw, r_q_neg, r_r_neg;
    logic [XLEN-1:0] r_rem, r_quo, r_dvs;
    logic [XLEN-1:0] r_quotient, r_remainder;
    logic [CW-1:0]   r_cnt;

    function automatic logic [XLEN-1:0] prep(input logic [XLEN-1:0] v, input logic w,
                                             input logic s);
        if (w) return {{(XLEN-WLEN){s & v[WLEN-1]}}, v[WLEN-1:0]};
        return v;
    endfunction

    function automatic logic [XLEN-1:0] fixup(input logic [XLEN-1:0] v, input logic neg,
                                              input logic w);
        logic [XLEN-1:0] t;
        t = neg ? -v : v;
        return w ? {{(XLEN-WLEN){t[WLEN-1]}}, t[WLEN-1:0]} : t;
    endfunction

    logic [XLEN-1:0] w_dvd_p, w_dvs_p, w_dvd_abs, w_dvs_abs;
    logic            w_dvd_neg, w_dvs_neg, w_div0, w_ovf, w_accept;

    assign w_dvd_p   = prep(bus.dividend, bus.divw, bus.div_signed);
    assign w_dvs_p   = prep(bus.divisor, bus.divw, bus.div_signed);
    assign w_dvd_neg = bus.div_signed & w_dvd_p[XLEN-1];
    assign w_dvs_neg = bus.div_signed & w_dvs_p[XLEN-1];
    assign w_dvd_abs = w_dvd_neg ? -w_dvd_p : w_dvd_p;
    assign w_dvs_abs = w_dvs_neg ? -w_dvs_p : w_dvs_p;
    assign w_div0    = (w_dvs_p == '0);
    assign w_ovf     = bus.div_signed & (w_dvd_p == (bus.divw ? MIN_W : MIN_X)) & (&w_dvs_p);
    assign w_accept  = bus.div_valid & (r_state == IDLE) & ~bus.flush;

    // The shifted partial remainder needs one extra bit before the trial subtract.
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_sub, w_rem_nx, w_quo_nx;
    logic            w_ge, w_last;

    assign w_shift  = {r_rem, r_quo[XLEN-1]};
    assign w_ge     = (w_shift >= {1'b0, r_dvs});
    assign w_sub    = w_shift[XLEN-1:0] - r_dvs;
    assign w_rem_nx = w_ge ? w_sub : w_shift[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};
    assign w_last   = (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: default first, so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        if (bus.flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_next = (w_div0 | w_ovf) ? DONE : CALC;
                CALC:    if (w_last) w_next = DONE;
                DONE:    if (bus.out_ready) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: only the visible results are reset; working registers load on accept.
        if (!rst_n || bus.flush) begin
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (w_accept) begin
            r_divw  <= bus.divw;
            r_q_neg <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg <= w_dvd_neg;
            r_dvs   <= w_dvs_abs;
            r_rem   <= '0;
            r_quo   <= bus.divw ? (w_dvd_abs << (XLEN - WLEN)) : w_dvd_abs;
            r_cnt   <= bus.divw ? CW'(WLEN) : CW'(XLEN);
            if (w_div0) begin
                r_quotient  <= fixup('1, 1'b0, bus.divw);
                r_remainder <= fixup(w_dvd_p, 1'b0, bus.divw);
            end else if (w_ovf) begin
                r_quotient  <= fixup(w_dvd_p, 1'b0, bus.divw);
                r_remainder <= '0;
            end
        end else if (r_state == CALC) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
                r_quotient  <= fixup(w_quo_nx, r_q_neg, r_divw);
                r_remainder <= fixup(w_rem_nx, r_r_neg, r_divw);
            end
        end
    end

    assign bus.div_ready = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
endmodule

// File: tb/tb_ysyx_22050133_div_unit.sv
// Scoreboard bench for the divider: directed operations push expected results,
// a negedge monitor pops and compares whenever a result is consumed.
module tb_ysyx_22050133_div_unit;
    localparam int XLEN = 64;
    typedef logic [XLEN-1:0] word_t;
    typedef struct {
        word_t q;
        word_t r;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    ysyx_22050133_div_unit_if #(.XLEN(XLEN)) bus ();

    ysyx_22050133_div_unit #(.XLEN(XLEN), .WLEN(XLEN / 2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input word_t act, input word_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got q=%h r=%h, want none",
                         bus.quotient, bus.remainder);
            end else begin
                e = exp_q.pop_front();
                check("quotient", bus.quotient, e.q);
                check("remainder", bus.remainder, e.r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input word_t q, input word_t r);
        exp_t e;
        e.q = q;
        e.r = r;
        exp_q.push_back(e);
    endtask

    // Presents operands while IDLE; returns just after the accepting edge.
    task automatic issue(input word_t dvd, input word_t dvs, input logic w, input logic s);
        check("div_ready_before_issue", word_t'(bus.div_ready), 1);
        bus.dividend   = dvd;
        bus.divisor    = dvs;
        bus.divw       = w;
        bus.div_signed = s;
        bus.div_valid  = 1'b1;
        tick();
        bus.div_valid  = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 200);
        check({name, "_latency"}, word_t'(n), word_t'(lat));
    endtask

    task automatic run_op(input string name, input word_t dvd, input word_t dvs,
                          input logic w, input logic s, input word_t q, input word_t r,
                          input int lat);
        push_exp(q, r);
        issue(dvd, dvs, w, s);
        wait_valid(name, lat);
        @(posedge clk);
        @(negedge clk);
        check({name, "_ready_after"}, word_t'(bus.div_ready), 1);
        check({name, "_valid_after"}, word_t'(bus.out_valid), 0);
    endtask

    initial begin
        bus.flush      = 1'b0;
        bus.div_valid  = 1'b1;
        bus.divw       = 1'b0;
        bus.div_signed = 1'b0;
        bus.dividend   = 64'd100;
        bus.divisor    = 64'd0;
        bus.out_ready  = 1'b1;

        // Operands held valid through reset must be ignored.
        repeat (3) tick();
        rst_n         = 1'b1;
        bus.div_valid = 1'b0;
        @(negedge clk);
        check("rst_div_ready", word_t'(bus.div_ready), 1);
        check("rst_out_valid", word_t'(bus.out_valid), 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);

        run_op("sdiv_m7_2", -64'sd7, 64'd2, 0, 1,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("udiv_by0", 64'd100, 64'd0, 0, 0, '1, 64'd100, 1);
        run_op("sdiv_ovf", 64'h8000_0000_0000_0000, '1, 0, 1,
               64'h8000_0000_0000_0000, 64'd0, 1);
        run_op("divuw_1", 64'h1_FFFF_FFFF, 64'd1, 1, 0, '1, 64'd0, 33);
        run_op("divw_m9_4", -64'sd9, 64'd4, 1, 1,
               64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("sdiv_m100_7", -64'sd100, 64'd7, 0, 1,
               64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op("sdiv_100_m7", 64'd100, -64'sd7, 0, 1,
               64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 65);
        run_op("udiv_max", '1, 64'h8000_0000_0000_0001, 0, 0,
               64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 65);
        run_op("sdiv_min_2", 64'h8000_0000_0000_0000, 64'd2, 0, 1,
               64'hC000_0000_0000_0000, 64'd0, 65);
        run_op("divw_ovf", 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 1,
               64'hFFFF_FFFF_8000_0000, 64'd0, 1);
        run_op("divuw_by0", 64'h1_8000_0005, 64'h5_0000_0000, 1, 0,
               '1, 64'hFFFF_FFFF_8000_0005, 1);
        run_op("divuw_3", 64'h8000_0000, 64'd3, 1, 0, 64'h2AAA_AAAA, 64'd2, 33);

        // Backpressure: result and handshake flags must hold while out_ready is low.
        bus.out_ready = 1'b0;
        push_exp(64'd333, 64'd1);
        issue(64'd1000, 64'd3, 0, 0);
        wait_valid("bp", 65);
        for (int i = 0; i < 5; i++) begin
            check("bp_quotient", bus.quotient, 64'd333);
            check("bp_remainder", bus.remainder, 64'd1);
            check("bp_out_valid", word_t'(bus.out_valid), 1);
            check("bp_div_ready", word_t'(bus.div_ready), 0);
            @(negedge clk);
        end
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_valid_after", word_t'(bus.out_valid), 0);
        check("bp_ready_after", word_t'(bus.div_ready), 1);

        // Flush at T+10 with div_valid high: nothing completes, nothing is accepted.
        issue(64'd1000, 64'd7, 0, 0);
        repeat (9) tick();
        bus.flush     = 1'b1;
        bus.div_valid = 1'b1;
        bus.dividend  = 64'd5;
        bus.divisor   = 64'd0;
        tick();
        bus.flush     = 1'b0;
        bus.div_valid = 1'b0;
        @(negedge clk);
        check("flush_div_ready", word_t'(bus.div_ready), 1);
        check("flush_out_valid", word_t'(bus.out_valid), 0);
        @(negedge clk);
        check("flush_still_idle", word_t'(bus.div_ready), 1);
        run_op("udiv_1000_7", 64'd1000, 64'd7, 0, 0, 64'd142, 64'd6, 65);

        // One-cycle reset in the middle of a calculation.
        issue(64'd12345, 64'd11, 0, 1);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_quotient", bus.quotient, 0);
        check("midrst_remainder", bus.remainder, 0);
        check("midrst_out_valid", word_t'(bus.out_valid), 0);
        check("midrst_div_ready", word_t'(bus.div_ready), 1);
        repeat (70) @(negedge clk);
        check("midrst_no_result", word_t'(bus.out_valid), 0);

        check("scoreboard_empty", word_t'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
